// File: rtl/mapper_mem_responder.sv
// mapper_mem_responder
//   Memory-side responder for one cartridge slot. Turns a mapped CPU read
//   (ram_cs/ram_addr from the mapper) into a req/ack read on the SDRAM
//   arbiter port, stalls the CPU with cpu_wait_o until the byte returns,
//   then holds that byte on cpu_data_o. Reads that hit no mapped RAM return
//   8'hFF without touching SDRAM. Writes are ignored (read-only window).
//
//   Optional build macro MAPPER_RESP_CACHE_EN adds a single-entry read cache
//   {tag, data, valid}; a hit skips the SDRAM access entirely.
//
// Ports
//   clk_i           system clock
//   reset_i         asynchronous active-high reset
//   cpu_req_i       one-cycle access strobe; cpu_rd_i/ram_cs_i/ram_addr_i
//                   are sampled with it
//   cpu_wait_o      combinational CPU stall
//   cpu_data_o      registered read data
//   cpu_data_vld_o  one-cycle pulse when cpu_data_o has been updated
//   sdram_req_o     read request level, held until ack or abort
//   sdram_addr_o    registered request address
//   sdram_ack_i     one-cycle acknowledge, sdram_dout_i valid with it
//   sdram_dout_i    SDRAM read byte
//   timeout_err_o   sticky abort flag, cleared only by reset
//
// State | meaning
//   IDLE  | no access in flight, accepting starts
//   WAIT  | request outstanding on SDRAM, counting toward timeout
//   DONE  | cpu_data_o updated this cycle, CPU still stalled
module mapper_mem_responder #(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_rd_i,
  input  logic              ram_cs_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  output logic              cpu_wait_o,
  output logic [7:0]        cpu_data_o,
  output logic              cpu_data_vld_o,
  output logic              sdram_req_o,
  output logic [ADDR_W-1:0] sdram_addr_o,
  input  logic              sdram_ack_i,
  input  logic [7:0]        sdram_dout_i,
  output logic              timeout_err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              sdram_req_q, sdram_req_d;
  logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
  logic [7:0]        cpu_data_q, cpu_data_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic start, unmapped_rd, hit, fill, abort, cache_clr;
  logic [7:0] cache_byte;

  assign start       = cpu_req_i & cpu_rd_i & ram_cs_i;
  assign unmapped_rd = cpu_req_i & cpu_rd_i & ~ram_cs_i;
  // Ack on the final timeout cycle still counts as a good read.
  assign fill        = (state_q == WAIT) & sdram_ack_i;
  assign abort       = (state_q == WAIT) & ~sdram_ack_i & (cnt_q == TO_LAST);
  assign cache_clr   = abort;

`ifdef MAPPER_RESP_CACHE_EN
  logic [ADDR_W-1:0] tag_q;
  logic [7:0]        cdata_q;
  logic              cvalid_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_q    <= '0;
      cdata_q  <= 8'hFF;
      cvalid_q <= 1'b0;
    end else if (fill) begin
      tag_q    <= sdram_addr_q;
      cdata_q  <= sdram_dout_i;
      cvalid_q <= 1'b1;
    end else if (cache_clr) begin
      cvalid_q <= 1'b0;
    end
  end

  assign hit        = cvalid_q & (tag_q == ram_addr_i);
  assign cache_byte = cdata_q;
`else
  assign hit        = 1'b0;
  assign cache_byte = 8'hFF;
`endif

  // State register (all sequential state of the responder).
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      cpu_data_q   <= 8'hFF;
      vld_q        <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      cpu_data_q   <= cpu_data_d;
      vld_q        <= vld_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = hit ? DONE : WAIT;
      WAIT:    if (fill || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. vld is set on entry to DONE so it pulses in DONE.
  always_comb begin
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    cpu_data_d   = cpu_data_q;
    vld_d        = 1'b0;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && hit) begin
          cpu_data_d = cache_byte;
          vld_d      = 1'b1;
        end else if (start) begin
          sdram_addr_d = ram_addr_i;
          sdram_req_d  = 1'b1;
          cnt_d        = 8'd0;
        end else if (unmapped_rd) begin
          cpu_data_d = 8'hFF;
          vld_d      = 1'b1;
        end
      end
      WAIT: begin
        if (fill) begin
          cpu_data_d  = sdram_dout_i;
          sdram_req_d = 1'b0;
          vld_d       = 1'b1;
        end else if (abort) begin
          cpu_data_d  = 8'hFF;
          sdram_req_d = 1'b0;
          err_d       = 1'b1;
          vld_d       = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign cpu_wait_o     = start | (state_q != IDLE);
  assign cpu_data_o     = cpu_data_q;
  assign cpu_data_vld_o = vld_q;
  assign sdram_req_o    = sdram_req_q;
  assign sdram_addr_o   = sdram_addr_q;
  assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_mapper_mem_responder.sv
// Bench for mapper_mem_responder, TIMEOUT reduced to 8. Expected read bytes
// are queued when each access is started and popped when cpu_data_vld fires.
module tb_mapper_mem_responder;

  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_rd = 1'b0, ram_cs = 1'b0;
  logic [AW-1:0] ram_addr = '0;
  logic          cpu_wait, cpu_data_vld, sdram_req, timeout_err;
  logic [7:0]    cpu_data;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack = 1'b0;
  logic [7:0]    sdram_dout = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];
  logic exp_err = 1'b0;

  mapper_mem_responder #(.ADDR_W(AW), .TIMEOUT(8)) dut (
    .clk_i(clk), .reset_i(rst),
    .cpu_req_i(cpu_req), .cpu_rd_i(cpu_rd), .ram_cs_i(ram_cs), .ram_addr_i(ram_addr),
    .cpu_wait_o(cpu_wait), .cpu_data_o(cpu_data), .cpu_data_vld_o(cpu_data_vld),
    .sdram_req_o(sdram_req), .sdram_addr_o(sdram_addr),
    .sdram_ack_i(sdram_ack), .sdram_dout_i(sdram_dout),
    .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU read; inputs change on the falling edge, outputs are sampled 1 ns later.
  task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic cs,
                         input int ack_at, input logic [7:0] dout, input logic [7:0] exp_data,
                         input int exp_wait, input int exp_req);
    int  wait_n = 0;
    int  req_n  = 0;
    bit  got    = 1'b0;
    logic [7:0] want;
    sb_q.push_back(exp_data);
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      cpu_req    = (k == 0);
      cpu_rd     = 1'b1;
      ram_cs     = cs;
      ram_addr   = addr;
      sdram_ack  = (k == ack_at);
      sdram_dout = (k == ack_at) ? dout : 8'hEE;
      #1;
      if (cpu_wait) wait_n++;
      if (sdram_req) begin
        req_n++;
        if (req_n == 1) chk({tag, "_sdram_addr"}, 32'(sdram_addr), 32'(addr));
      end
      if (cpu_data_vld) begin
        got = 1'b1;
        if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        else begin
          want = sb_q.pop_front();
          chk({tag, "_data"}, 32'(cpu_data), 32'(want));
        end
      end
    end
    chk({tag, "_vld_seen"}, 32'(got), 32'd1);
    if (!got) sb_q.delete();
    @(negedge clk);
    cpu_req = 1'b0; cpu_rd = 1'b0; ram_cs = 1'b0; sdram_ack = 1'b0;
    #1;
    chk({tag, "_wait_low"}, 32'(cpu_wait), 32'd0);
    chk({tag, "_vld_pulse"}, 32'(cpu_data_vld), 32'd0);
    chk({tag, "_data_hold"}, 32'(cpu_data), 32'(exp_data));
    chk({tag, "_wait_cycles"}, 32'(wait_n), 32'(exp_wait));
    chk({tag, "_req_cycles"}, 32'(req_n), 32'(exp_req));
    chk({tag, "_err"}, 32'(timeout_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_data", 32'(cpu_data), 32'hFF);
    chk("rst_vld", 32'(cpu_data_vld), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_wait", 32'(cpu_wait), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Stray ack while idle must change nothing
    @(negedge clk);
    sdram_ack = 1'b1; sdram_dout = 8'h55;
    @(negedge clk);
    sdram_ack = 1'b0;
    #1;
    chk("idle_ack_data", 32'(cpu_data), 32'hFF);
    chk("idle_ack_vld", 32'(cpu_data_vld), 32'd0);
    chk("idle_ack_req", 32'(sdram_req), 32'd0);

    // Mapped read, ack three cycles after start
    do_read("hit_path", 27'h0002005, 1'b1, 3, 8'h5A, 8'h5A, 5, 3);
    // Unmapped read: FF, no stall, no SDRAM traffic
    do_read("unmapped", 27'h0002005, 1'b0, -1, 8'h00, 8'hFF, 0, 0);
    // Ack lands on the last allowed WAIT cycle
    do_read("ack_last", 27'h0001234, 1'b1, 8, 8'h3C, 8'h3C, 10, 8);
    // No ack: abort after 8 WAIT cycles
    exp_err = 1'b1;
    do_read("timeout", 27'h0001235, 1'b1, -1, 8'h00, 8'hFF, 10, 8);
    // Error stays set across a good read
    do_read("sticky", 27'h0002006, 1'b1, 1, 8'h11, 8'h11, 3, 1);

    // Reset in the middle of WAIT
    @(negedge clk);
    cpu_req = 1'b1; cpu_rd = 1'b1; ram_cs = 1'b1; ram_addr = 27'h0003000;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    chk("midwait_req", 32'(sdram_req), 32'd1);
    rst = 1'b1;
    exp_err = 1'b0;
    #1;
    chk("midrst_req", 32'(sdram_req), 32'd0);
    chk("midrst_data", 32'(cpu_data), 32'hFF);
    chk("midrst_wait", 32'(cpu_wait), 32'd0);
    chk("midrst_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; ram_cs = 1'b0; cpu_rd = 1'b0;

    // Cache scenario (default build: every read goes to SDRAM)
    do_read("fill", 27'h0004000, 1'b1, 2, 8'hC3, 8'hC3, 4, 2);
`ifdef MAPPER_RESP_CACHE_EN
    do_read("reread", 27'h0004000, 1'b1, -1, 8'h00, 8'hC3, 2, 0);
`else
    do_read("reread", 27'h0004000, 1'b1, 2, 8'hC3, 8'hC3, 4, 2);
`endif
    do_read("newaddr", 27'h0004001, 1'b1, 2, 8'h77, 8'h77, 4, 2);
    // An abort must invalidate the cached entry
    exp_err = 1'b1;
    do_read("to_inval", 27'h0004002, 1'b1, -1, 8'h00, 8'hFF, 10, 8);
    do_read("after_to", 27'h0004001, 1'b1, 2, 8'h99, 8'h99, 4, 2);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
